// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks pc through instruction memory and
// buffers fetched words in a two-entry queue for the consumer. A branch
// redirects fetch and flushes the queue. When pc leaves the memory range,
// fetch wraps back to RESET_PC and wrap pulses for one cycle.
module fetch_ctrl #(
  parameter int unsigned MAX_SIZE = 1024,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_address,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instruction,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        wrap,
  output logic        misalign
);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;

  localparam logic [31:0] MAX_WORD = 32'(MAX_SIZE - 1);
  localparam logic [1:0]  DEPTH_C  = 2'(DEPTH);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        wrap_q, wrap_d;
  logic        misalign_q, misalign_d;

  // Queue payload; contents are only meaningful while counted, so no reset
  logic [31:0] ent_pc_q  [2];
  logic [31:0] ent_ins_q [2];

  logic        range_ok;
  logic        pop;
  logic        fetch_ok;
  logic        tail;

  // Handshake qualifiers shared by the next-state logic and the queue write
  always_comb begin
    range_ok = ({2'b00, pc_q[31:2]} <= MAX_WORD);
    pop      = (count_q != 2'd0) && inst_ready && !stall && !branch;
    fetch_ok = (state_q == FETCH) && !stall && !branch && range_ok &&
               ((count_q < DEPTH_C) || pop);
    // With two slots the tail is the head when empty or full, else the other slot
    tail     = head_q ^ count_q[0];
  end

  // Next-state logic: branch overrides everything, stall freezes the rest
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    head_d     = head_q;
    wrap_d     = 1'b0;
    misalign_d = misalign_q;
    if (branch) begin
      state_d    = FETCH;
      pc_d       = {branch_address[31:2], 2'b00};
      count_d    = 2'd0;
      misalign_d = misalign_q | (branch_address[1:0] != 2'b00);
    end else begin
      count_d = count_q + {1'b0, fetch_ok} - {1'b0, pop};
      head_d  = head_q ^ pop;
      if (fetch_ok) begin
        pc_d = pc_q + 32'd4;
      end
      if (!stall) begin
        unique case (state_q)
          IDLE: begin
            if (go) begin
              state_d = FETCH;
            end
          end
          FETCH: begin
            if (!range_ok) begin
              pc_d   = RESET_PC;
              wrap_d = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Control state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      wrap_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      wrap_q     <= wrap_d;
      misalign_q <= misalign_d;
    end
  end

  // Capture the fetched word and its address into the tail slot
  always_ff @(posedge clk) begin
    if (fetch_ok) begin
      ent_pc_q[tail]  <= pc_q;
      ent_ins_q[tail] <= imem_instruction;
    end
  end

  // Output drive; head fields are forced to zero while the queue is empty
  always_comb begin
    imem_en    = fetch_ok;
    imem_addr  = pc_q;
    inst_valid = (count_q != 2'd0);
    inst_out   = inst_valid ? ent_ins_q[head_q] : 32'd0;
    inst_pc    = inst_valid ? ent_pc_q[head_q]  : 32'd0;
    wrap       = wrap_q;
    misalign   = misalign_q;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a queue-based reference model predicts
// which {pc, instruction} pairs enter the queue; a negedge monitor compares
// every presented head and status output and retires entries on handshake.
module tb_fetch_ctrl;

  localparam int unsigned MAX_SIZE = 1024;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_address = 32'd0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        wrap;
  logic        misalign;

  fetch_ctrl #(.MAX_SIZE(MAX_SIZE), .RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .go(go), .stall(stall), .branch(branch),
    .branch_address(branch_address), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_instruction(imem_instruction), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .wrap(wrap), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Memory image: word i holds value i
  assign imem_instruction = {2'b00, imem_addr[31:2]};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        sb_q[$];
  bit          m_fetch = 1'b0;
  logic [31:0] m_pc = RESET_PC;
  bit          exp_wrap = 1'b0;
  bit          exp_mis = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_range(input logic [31:0] p);
    return (p >> 2) <= (MAX_SIZE - 1);
  endfunction

  // Monitor: mid-cycle compare of everything the DUT presents
  bit hs;
  bit exp_en;
  always @(negedge clk) begin
    hs     = reset && (sb_q.size() != 0) && inst_ready && !stall && !branch;
    exp_en = reset && m_fetch && !stall && !branch && in_range(m_pc) &&
             ((sb_q.size() < 2) || hs);
    check("inst_valid", {31'd0, inst_valid}, {31'd0, sb_q.size() != 0});
    if (sb_q.size() != 0) begin
      check("inst_pc", inst_pc, sb_q[0].pc);
      check("inst_out", inst_out, sb_q[0].ins);
    end else begin
      check("inst_pc_empty", inst_pc, 32'd0);
      check("inst_out_empty", inst_out, 32'd0);
    end
    check("imem_addr", imem_addr, m_pc);
    check("imem_en", {31'd0, imem_en}, {31'd0, exp_en});
    check("wrap", {31'd0, wrap}, {31'd0, exp_wrap});
    check("misalign", {31'd0, misalign}, {31'd0, exp_mis});
    if (hs) void'(sb_q.pop_front());
  end

  // Reference model: effect of the upcoming clock edge, from the rules
  task automatic model_step();
    exp_wrap = 1'b0;
    if (branch) begin
      sb_q.delete();
      m_pc    = {branch_address[31:2], 2'b00};
      m_fetch = 1'b1;
      if (branch_address[1:0] != 2'b00) exp_mis = 1'b1;
    end else if (!stall) begin
      if (!m_fetch) begin
        if (go) m_fetch = 1'b1;
      end else if (!in_range(m_pc)) begin
        m_pc     = RESET_PC;
        exp_wrap = 1'b1;
      end else if (sb_q.size() < 2) begin
        sb_q.push_back({m_pc, m_pc >> 2});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // One clock: drive at posedge+1, model at posedge+7, return at next posedge+1
  task automatic cyc(input bit g, input bit st, input bit br,
                     input logic [31:0] ba, input bit rdy);
    go = g; stall = st; branch = br; branch_address = ba; inst_ready = rdy;
    #6;
    if (reset) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0, rdy);
  endtask

  // Asynchronous reset mid-cycle with immediate output checks
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_out", inst_out, 32'd0);
    check("rst_wrap", {31'd0, wrap}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_en", {31'd0, imem_en}, 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    sb_q.delete();
    m_fetch  = 1'b0;
    m_pc     = RESET_PC;
    exp_wrap = 1'b0;
    exp_mis  = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] ba;
    @(posedge clk);
    #1;
    do_reset();

    // Continuous stream with consumer always ready
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    run(20, 1'b1);

    // Back-pressure from the start, then drain
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    run(4, 1'b0);
    check("bp_pc_hold", imem_addr, 32'h8);
    run(10, 1'b1);

    // Flush of a full queue by a branch
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
    run(3, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
    check("flush_valid", {31'd0, inst_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("flush_target", inst_pc, 32'h200);
    run(5, 1'b1);

    // Misaligned branch target, sticky until reset
    cyc(1'b0, 1'b0, 1'b1, 32'h203, 1'b1);
    run(6, 1'b1);

    // Wrap at the top of memory
    cyc(1'b0, 1'b0, 1'b1, 32'hFF8, 1'b1);
    run(8, 1'b1);

    // Stall mid-stream, resume, then reset mid-stream
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    run(5, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    run(5, 1'b1);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        ba = $urandom_range(0, 32'h1010);
        if ($urandom_range(0, 3) != 0) ba[1:0] = 2'b00;
        cyc($urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 19) == 0, ba, $urandom_range(0, 9) < 7);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
